wave_gen: RTL

- Programmable square-wave transmitter. It is the generating end of the period-measurement path: it emits a wave on Cout whose period and high time are set in Clk cycles.
- It can emit a fixed burst or run continuously, and counts the periods it has emitted.
- It drives the measurement counter's Cin in loopback tests and also serves as a standalone stimulus source.

---
 rtl/wave_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/wave_gen.sv
// wave_gen: programmable square-wave transmitter.
//
// Emits a wave on Cout whose period and high time are counted in Clk cycles, either as a
// fixed burst of periods or continuously, and counts the complete periods emitted in M.
// Parameters are loaded into shadow registers and copied into the active registers on
// start (from IDLE) or at a period boundary (in RUN), so the output never glitches.
//
// Optional feature (macro WAVE_GEN_EDGE_PULSE_EN): adds output edge_p, a one-cycle pulse
// coincident with every rising edge of Cout.
//
// Ports:
//   Clk        system clock
//   Rst_n      asynchronous active-low reset
//   period_in  wave period in Clk cycles (>= 2, smaller values rejected with err)
//   high_in    high time; 0 selects period_in>>1, values >= period_in clamp to period_in-1
//   burst_in   periods to emit; 0 runs continuously
//   load       strobe: capture period_in/high_in/burst_in into the shadow registers
//   start      strobe: begin emission (honoured only in IDLE)
//   stop       strobe: finish the current period, then return to IDLE
//   Cout       generated wave
//   busy       high while running
//   done       one-cycle pulse when emission ends (burst complete or stop)
//   err        one-cycle pulse after a rejected load
//   M          complete periods emitted since the last start
//   edge_p     (optional) rising-edge pulse aligned with Cout
module wave_gen #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NUM_W = 25
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] high_in,
    input  logic [NUM_W-1:0] burst_in,
    input  logic             load,
    input  logic             start,
    input  logic             stop,
    output logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NUM_W-1:0] M
`ifdef WAVE_GEN_EDGE_PULSE_EN
    ,
    output logic             edge_p
`endif
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ph_q, ph_d;
    logic [NUM_W-1:0] m_q, m_d;
    logic             stop_q, stop_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
    logic [NUM_W-1:0] sh_burst_q, sh_burst_d;
    logic [CNT_W-1:0] act_per_q, act_per_d, act_high_q, act_high_d;
    logic [NUM_W-1:0] act_burst_q, act_burst_d;

    logic             ld_ok;
    logic [CNT_W-1:0] ld_high;

    assign ld_ok = load && (period_in >= CNT_W'(2));

    always_comb begin
        if (high_in == '0) begin
            ld_high = period_in >> 1;
        end else if (high_in >= period_in) begin
            ld_high = period_in - CNT_W'(1);
        end else begin
            ld_high = high_in;
        end
    end

    // Shadow next-state doubles as the value applied at a coincident start or boundary,
    // so a load landing on that same edge takes effect immediately.
    always_comb begin
        sh_per_d   = sh_per_q;
        sh_high_d  = sh_high_q;
        sh_burst_d = sh_burst_q;
        if (ld_ok) begin
            sh_per_d   = period_in;
            sh_high_d  = ld_high;
            sh_burst_d = burst_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        m_d         = m_q;
        stop_d      = stop_q;
        done_d      = 1'b0;
        err_d       = load && !ld_ok;
        act_per_d   = act_per_q;
        act_high_d  = act_high_q;
        act_burst_d = act_burst_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StRun;
                    ph_d        = CNT_W'(1);
                    m_d         = '0;
                    stop_d      = 1'b0;
                    act_per_d   = sh_per_d;
                    act_high_d  = sh_high_d;
                    act_burst_d = sh_burst_d;
                end
            end
            StRun: begin
                if (ph_q == act_per_q) begin
                    m_d         = m_q + NUM_W'(1);
                    act_per_d   = sh_per_d;
                    act_high_d  = sh_high_d;
                    act_burst_d = sh_burst_d;
                    if (((sh_burst_d != '0) && (m_d == sh_burst_d)) || stop || stop_q) begin
                        state_d = StIdle;
                        ph_d    = '0;
                        stop_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        ph_d = CNT_W'(1);
                    end
                end else begin
                    ph_d = ph_q + CNT_W'(1);
                    if (stop) begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered from next-state values so Cout lines up with the phase it describes.
        cout_d = (state_d == StRun) && (ph_d <= act_high_d);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            ph_q        <= '0;
            m_q         <= '0;
            stop_q      <= 1'b0;
            cout_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sh_per_q    <= CNT_W'(2);
            sh_high_q   <= CNT_W'(1);
            sh_burst_q  <= '0;
            act_per_q   <= CNT_W'(2);
            act_high_q  <= CNT_W'(1);
            act_burst_q <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            m_q         <= m_d;
            stop_q      <= stop_d;
            cout_q      <= cout_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sh_per_q    <= sh_per_d;
            sh_high_q   <= sh_high_d;
            sh_burst_q  <= sh_burst_d;
            act_per_q   <= act_per_d;
            act_high_q  <= act_high_d;
            act_burst_q <= act_burst_d;
        end
    end

`ifdef WAVE_GEN_EDGE_PULSE_EN
    logic edge_q, edge_d;

    assign edge_d = (state_d == StRun) && (ph_d == CNT_W'(1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            edge_q <= 1'b0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign edge_p = edge_q;
`endif

    assign Cout = cout_q;
    assign busy = (state_q == StRun);
    assign done = done_q;
    assign err  = err_q;
    assign M    = m_q;

endmodule
